// File: rtl/spi_slave_frame_rx_pkg.sv
// rtl/spi_slave_frame_rx_pkg.sv - shared constants, command codes and FSM states for the SPI frame receiver
package spi_slave_frame_rx_pkg;

    localparam int LEN_SPI      = 32;
    localparam int SPI_CODE_LEN = 6;
    localparam int SPI_ADDR_LEN = 10;
    localparam int SPI_DATA_LEN = 16;
    localparam int SYNC_STAGES  = 2;

    // bit counter saturates one past a full frame so long frames stay distinguishable
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] FRAME_BITS = CNT_W'(LEN_SPI);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(LEN_SPI + 1);

    typedef enum logic [SPI_CODE_LEN-1:0] {
        CMD_NOP        = 6'd0,
        CMD_RD_ID      = 6'd1,
        CMD_WR_STIM    = 6'd2,
        CMD_RD_STIM    = 6'd3,
        CMD_WR_REC     = 6'd4,
        CMD_RD_REC     = 6'd5,
        CMD_WR_CFG     = 6'd6,
        CMD_RD_CFG     = 6'd7,
        CMD_WR_REG     = 6'd8,
        CMD_RD_REG     = 6'd9,
        CMD_STIM_START = 6'd10,
        CMD_STIM_STOP  = 6'd11,
        CMD_REC_START  = 6'd12,
        CMD_REC_STOP   = 6'd13,
        CMD_WR_IMP     = 6'd14,
        CMD_RD_IMP     = 6'd15,
        CMD_WR_CB      = 6'd16,
        CMD_RD_CB      = 6'd17,
        CMD_CB_OK_LOW  = 6'd18,
        CMD_RD_ADC     = 6'd19,
        CMD_WR_ADC_CFG = 6'd20,
        CMD_RD_STATUS  = 6'd21,
        CMD_CLR_STATUS = 6'd22,
        CMD_SOFT_RST   = 6'd23,
        CMD_ECHO       = 6'd24
    } spi_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_slave_frame_rx_pin_sync.sv
// rtl/spi_slave_frame_rx_pin_sync.sv - multi-flop synchronizer plus edge detector for one SPI pin
module spi_pin_sync #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // shift the raw pin through the synchronizer chain; reset parks it at the pin's idle level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{IDLE_VAL}};
            prev_q <= IDLE_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_frame_rx.sv
// rtl/spi_slave_frame_rx.sv - SPI responder: decodes 32-bit LSB-first command frames and returns read data
module spi_slave_frame_rx
    import spi_slave_frame_rx_pkg::*;
#(
    parameter int SYNC_N = SYNC_STAGES
) (
    input  logic                    clk_50M,
    input  logic                    rst_n,
    input  logic                    sck,
    input  logic                    mosi,
    input  logic                    cs_n,
    output logic                    miso,
    output logic                    cmd_valid,
    output logic [SPI_CODE_LEN-1:0] cmd_code,
    output logic [SPI_ADDR_LEN-1:0] cmd_addr,
    output logic [SPI_DATA_LEN-1:0] cmd_data,
    input  logic [LEN_SPI-1:0]      rd_data,
    input  logic                    rd_data_valid,
    output logic                    frame_err,
    output logic                    busy
);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_ok;

    spi_pin_sync #(.STAGES(SYNC_N), .IDLE_VAL(1'b1)) u_sync_sck (
        .clk(clk_50M), .rst_n(rst_n), .pin(sck),
        .level(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_N), .IDLE_VAL(1'b1)) u_sync_cs (
        .clk(clk_50M), .rst_n(rst_n), .pin(cs_n),
        .level(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_N), .IDLE_VAL(1'b0)) u_sync_mosi (
        .clk(clk_50M), .rst_n(rst_n), .pin(mosi),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_ok = &{1'b0, sck_s, sck_fall, cs_s, mosi_rise, mosi_fall};

    spi_state_e         state_q, state_d;
    logic [LEN_SPI-1:0] rx_shift, tx_shift, tx_hold;
    logic [CNT_W-1:0]   bit_cnt;

    // frame state register
    always_ff @(posedge clk_50M) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // frame sequencing: wait for select, shift until deselect, one closing cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
            ST_SHIFT: if (cs_rise) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // response staging: a strobe coinciding with frame start bypasses the hold register
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            tx_hold  <= '0;
            tx_shift <= '0;
        end else begin
            if (state_q == ST_IDLE && cs_fall) begin
                tx_shift <= rd_data_valid ? rd_data : tx_hold;
                tx_hold  <= '0;
            end else begin
                if (rd_data_valid) tx_hold <= rd_data;
                if (state_q == ST_SHIFT && sck_rise) tx_shift <= tx_shift >> 1;
            end
        end
    end

    // receive shifter and saturating bit counter
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else if (state_q == ST_IDLE && cs_fall) begin
            bit_cnt <= '0;
        end else if (state_q == ST_SHIFT && sck_rise) begin
            rx_shift <= {mosi_s, rx_shift[LEN_SPI-1:1]};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // frame close: publish a good frame or flag a bad one for a single cycle
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            cmd_code  <= '0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            if (state_q == ST_DONE) begin
                if (bit_cnt == FRAME_BITS) begin
                    cmd_valid <= 1'b1;
                    cmd_code  <= rx_shift[LEN_SPI-1 -: SPI_CODE_LEN];
                    cmd_addr  <= rx_shift[SPI_DATA_LEN +: SPI_ADDR_LEN];
                    cmd_data  <= rx_shift[SPI_DATA_LEN-1:0];
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    assign miso = (state_q == ST_SHIFT) & tx_shift[0];
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// tb/tb_spi_slave_frame_rx.sv - self-checking bench for spi_slave_frame_rx
module tb_spi_slave_frame_rx;

    logic        clk_50M = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b1;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;
    logic [31:0] rd_data = '0;
    logic        rd_data_valid = 1'b0;
    logic        miso, cmd_valid, frame_err, busy;
    logic [5:0]  cmd_code;
    logic [9:0]  cmd_addr;
    logic [15:0] cmd_data;

    spi_slave_frame_rx dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .sck(sck), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #10 clk_50M = ~clk_50M;

    int n_cmp = 0;
    int n_bad = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;

    // count every cycle each strobe is high; a pulse wider than one cycle shows up as an extra count
    always @(negedge clk_50M) begin
        if (cmd_valid) cv_cnt <= cv_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    logic [31:0] m_hold = '0;
    int          m_cv = 0;
    int          m_fe = 0;
    logic [5:0]  m_code = '0;
    logic [9:0]  m_addr = '0;
    logic [15:0] m_data = '0;
    logic [39:0] exp_miso, cap, fbits;
    logic [31:0] w;
    int          nb;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_rd(input logic [31:0] word);
        @(negedge clk_50M);
        rd_data = word;
        rd_data_valid = 1'b1;
        @(negedge clk_50M);
        rd_data_valid = 1'b0;
        m_hold = word;
    endtask

    task automatic spi_frame(input logic [39:0] bits, input int n, input bit coinc,
                             input logic [31:0] cw, output logic [39:0] got);
        got = '0;
        @(negedge clk_50M);
        cs_n = 1'b0;
        @(negedge clk_50M);
        @(negedge clk_50M);
        if (coinc) begin
            rd_data = cw;
            rd_data_valid = 1'b1;
        end
        @(negedge clk_50M);
        rd_data_valid = 1'b0;
        #40;
        for (int i = 0; i < n; i++) begin
            mosi = bits[i];
            #50 sck = 1'b0;
            got[i] = miso;
            #100 sck = 1'b1;
            #50;
        end
        #100 cs_n = 1'b1;
        mosi = 1'b0;
        #400;
    endtask

    // reference: response is whatever was staged before the frame, a full frame decodes by field slicing
    task automatic model_frame(input logic [39:0] bits, input int n, input bit coinc, input logic [31:0] cw);
        logic [31:0] resp;
        resp = coinc ? cw : m_hold;
        m_hold = '0;
        exp_miso = '0;
        for (int i = 0; i < n && i < 32; i++) exp_miso[i] = resp[i];
        if (n == 32) begin
            m_cv++;
            m_code = bits[31:26];
            m_addr = bits[25:16];
            m_data = bits[15:0];
        end else begin
            m_fe++;
        end
    endtask

    task automatic run_frame(input string tag, input logic [39:0] bits, input int n,
                             input bit coinc, input logic [31:0] cw);
        model_frame(bits, n, coinc, cw);
        spi_frame(bits, n, coinc, cw, cap);
        check({tag, ".miso"}, 64'(cap), 64'(exp_miso));
        check({tag, ".cmd_valid_cnt"}, 64'(cv_cnt), 64'(m_cv));
        check({tag, ".frame_err_cnt"}, 64'(fe_cnt), 64'(m_fe));
        check({tag, ".cmd_code"}, 64'(cmd_code), 64'(m_code));
        check({tag, ".cmd_addr"}, 64'(cmd_addr), 64'(m_addr));
        check({tag, ".cmd_data"}, 64'(cmd_data), 64'(m_data));
    endtask

    initial begin
        repeat (5) @(negedge clk_50M);
        check("reset.outputs", {cmd_valid, frame_err, busy, miso, cmd_code, cmd_addr, cmd_data}, 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_50M);
        check("idle.busy_miso", {busy, miso}, 64'd0);

        run_frame("f8", {8'h0, 6'd8, 10'd4, 16'h0}, 32, 1'b0, '0);
        run_frame("f16", {8'h0, 6'd16, 8'd2, 2'd0, 16'h6910}, 32, 1'b0, '0);

        load_rd(32'h0000_0001);
        run_frame("rd1", {8'h0, 32'h1234_5678}, 32, 1'b0, '0);
        run_frame("rd_stale", {8'h0, 32'h0BAD_F00D}, 32, 1'b0, '0);

        fbits = {$urandom, $urandom};
        run_frame("short20", fbits, 20, 1'b0, '0);
        fbits = {$urandom, $urandom};
        run_frame("long33", fbits, 33, 1'b0, '0);
        run_frame("zero_len", '0, 0, 1'b0, '0);

        for (int i = 0; i < 6; i++) begin
            #100 sck = 1'b0;
            #100 sck = 1'b1;
        end
        #200;
        check("glitch.cmd_valid_cnt", 64'(cv_cnt), 64'(m_cv));
        check("glitch.frame_err_cnt", 64'(fe_cnt), 64'(m_fe));

        load_rd($urandom);
        @(negedge clk_50M);
        cs_n = 1'b0;
        #200;
        for (int i = 0; i < 10; i++) begin
            mosi = 1'($urandom);
            #50 sck = 1'b0;
            #100 sck = 1'b1;
            #50;
        end
        @(negedge clk_50M);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50M);
        check("midreset.outputs", {cmd_valid, frame_err, busy, miso, cmd_code, cmd_addr, cmd_data}, 64'd0);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;
        m_hold = '0;
        m_code = '0;
        m_addr = '0;
        m_data = '0;
        repeat (5) @(negedge clk_50M);
        run_frame("post_reset", {8'h0, 6'd3, 10'h3FF, 16'hFFFF}, 32, 1'b0, '0);

        load_rd(32'h1357_9BDF);
        run_frame("coinc", {8'h0, 6'd19, 10'h055, 16'hC0DE}, 32, 1'b1, 32'hA5A5_5A5A);
        run_frame("coinc_next", {8'h0, 6'd18, 10'h2AA, 16'h0F0F}, 32, 1'b0, '0);

        for (int r = 0; r < 6; r++) begin
            for (int k = $urandom_range(0, 3); k > 0; k--) load_rd($urandom);
            fbits = {8'h0, $urandom};
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 34) : 32;
            w = $urandom;
            run_frame($sformatf("rand%0d", r), fbits, nb, 1'($urandom_range(0, 1)), w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
